twiddle_mul: RTL and testbench
==============================

Name: twiddle_mul

Overview:
- Twiddle-factor rotator between two sdf2 stage pairs in the radix-2^2 SDF pipeline.
- Consumes the streaming complex output of the upstream sdf2 pair and multiplies each valid sample by W_N^e.
- Feeds the result, with its aligned enable, to the next sdf2 stage.
- Fully pipelined, one sample per clock, gaps in the stream allowed.

Parameters:
- WIDTH, 8: signed data width of in/out real and imaginary parts.
- TW_WIDTH, 8: signed twiddle width, Q1.(TW_WIDTH-1) format.
- N, 16: FFT span of this stage; power of 2, at least 4.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable_in  input  1  in_re/in_im carry a valid sample this cycle.
- in_re  input  WIDTH  signed real input.
- in_im  input  WIDTH  signed imaginary input.
- enable_out  output  1  out_re/out_im valid.
- out_re  output  WIDTH  signed real result.
- out_im  output  WIDTH  signed imaginary result.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: out_re=0, out_im=0, enable_out=0. Sample counter and all pipeline registers, including valid bits, cleared.
- Sample counter k: range 0..N-1. Increments only on enable_in=1 and wraps N-1 -> 0. Holds during enable_in=0 gaps.
- Exponent derivation:
  - q = k / (N/4), m = k mod (N/4).
  - e = m * M[q], with M = {0,2,1,3}.
  - e ranges 0..3(N/4-1), no modulo needed.
- Twiddle: wr = Q(cos(2*pi*e/N)), wi = -Q(sin(2*pi*e/N)).
  - Q(x) = round(x * 2^(TW_WIDTH-1)), clamped to 2^(TW_WIDTH-1)-1.
  - Values come from a registered ROM indexed by e.
- Product:
  - re = in_re*wr - in_im*wi
  - im = in_re*wi + in_im*wr
  - Full precision WIDTH+TW_WIDTH+1 bits.
- Scaling: add 2^(TW_WIDTH-2), then arithmetic shift right by TW_WIDTH-1 (round half up). Then saturate or wrap to WIDTH (see Optional Feature).
- Exact bypass: when e==0 (unity twiddle, not representable in Q1.x), output equals input unmodified, with identical latency.
- Pipeline:
  - Stage 1: register input and ROM twiddle, plus the bypass flag.
  - Stage 2: register the four products.
  - Stage 3: add/subtract, round, saturate, bypass mux into out_re/out_im.
  - Latency is exactly 3 cycles from enable_in to enable_out.
- Enable and data during gaps:
  - enable_out is enable_in delayed 3 cycles.
  - Output data during enable_out=0 is don't-care, but must be deterministic (pipeline computes regardless).
- Reset mid-frame: asynchronous clear. The first valid sample after rst_n release is k=0. In-flight samples are discarded (enable_out stays 0).

Optional Feature:
- Macro TWIDDLE_MUL_SAT_EN.
- Defined: the stage-3 result clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Undefined: the stage-3 result is truncated to its low WIDTH bits (two's-complement wrap).
- Latency is identical in both cases.

Decomposition:
- Shared package:
  - exponent map constant M = {0,2,1,3}
  - rounding-offset helper function
  - saturate function (parameterised width)
- Sub-module twiddle_rom:
  - parameters N, TW_WIDTH; address width $clog2(N); registered wr/wi outputs.
  - Table generated at elaboration from cos/sin using the Q() rule above.

Test Plan (N=16, WIDTH=8, TW_WIDTH=8):
1. Reset: hold rst_n=0 while driving enable_in=1 and in=(100,-50) -> out=(0,0), enable_out=0 throughout. Release -> first enable_out exactly 3 cycles after the first accepted sample.
2. k=0..4 (e=0), in=(100,-50) -> out=(100,-50) exactly, 3 cycles later, enable_out=1 each cycle.
3. k=5 (q=1, m=1, e=2, wr=91, wi=-91), in=(64,0) -> out=(46,-45).
4. k=5, in=(-128,-128):
   - with TWIDDLE_MUL_SAT_EN: out=(-128,0).
   - without the macro: out=(74,0).
5. Gaps: 3 idle cycles inserted after k=6 -> next valid sample still uses k=7 (q=1, m=3, e=6). After 16 valid samples, the next one uses k=0 (bypass).
6. rst_n pulsed low asynchronously (mid-cycle) at k=9 with samples in flight -> enable_out drops immediately. No in-flight sample emerges. The post-release first sample is treated as k=0 (passes through unchanged).

Source files
------------

// File: rtl/twiddle_mul_pkg.sv
// Shared constants and arithmetic helpers for the twiddle_mul rotator.
// Saturation is used only when TWIDDLE_MUL_SAT_EN is defined.
package twiddle_mul_pkg;

    // Quadrant -> exponent multiplier, indexed by q = k / (N/4): {0,2,1,3}
    localparam logic [3:0][1:0] M_MAP = {2'd3, 2'd1, 2'd2, 2'd0};

    // Half-LSB offset for round-half-up before dropping frac_bits bits
    function automatic int round_ofs(input int frac_bits);
        return (frac_bits > 0) ? (1 << (frac_bits - 1)) : 0;
    endfunction

    // Clamp a signed value into the range of a w-bit two's-complement number
    function automatic logic signed [31:0] sat_to(input logic signed [31:0] x, input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/twiddle_mul_rom.sv
// Registered twiddle ROM: wr = Q(cos(2*pi*e/N)), wi = -Q(sin(2*pi*e/N)), Q1.(TW_WIDTH-1).
// Table is built at elaboration; +1.0 clamps to the largest positive code.
module twiddle_rom #(
    parameter int N        = 16,
    parameter int TW_WIDTH = 8,
    localparam int AW      = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AW-1:0]              addr_i,
    output logic signed [TW_WIDTH-1:0] wr_o,
    output logic signed [TW_WIDTH-1:0] wi_o
);
    localparam real PI    = 3.14159265358979323846;
    localparam int  QMAX  = (1 << (TW_WIDTH - 1)) - 1;
    localparam real SCALE = real'(1 << (TW_WIDTH - 1));

    logic signed [TW_WIDTH-1:0] wr_tab [N];
    logic signed [TW_WIDTH-1:0] wi_tab [N];

    for (genvar a = 0; a < N; a++) begin : g_tab
        localparam real ANG = 2.0 * PI * a / N;
        localparam real CR  = $cos(ANG) * SCALE;
        localparam real SR  = $sin(ANG) * SCALE;
        localparam int  CI  = (CR >= 0.0) ? $rtoi(CR + 0.5) : -$rtoi(0.5 - CR);
        localparam int  SI  = (SR >= 0.0) ? $rtoi(SR + 0.5) : -$rtoi(0.5 - SR);
        localparam int  WR  = (CI > QMAX) ? QMAX : CI;
        localparam int  WI  = -((SI > QMAX) ? QMAX : SI);
        assign wr_tab[a] = TW_WIDTH'(WR);
        assign wi_tab[a] = TW_WIDTH'(WI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_o <= '0;
            wi_o <= '0;
        end else begin
            wr_o <= wr_tab[addr_i];
            wi_o <= wi_tab[addr_i];
        end
    end

endmodule

// File: rtl/twiddle_mul.sv
// Radix-2^2 SDF twiddle rotator: multiplies each valid sample by W_N^e, 3-cycle latency.
// Define TWIDDLE_MUL_SAT_EN to saturate the rounded result instead of wrapping it.
module twiddle_mul
    import twiddle_mul_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int TW_WIDTH = 8,
    parameter int N        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable_in,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    enable_out,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im
);
    localparam int KW     = $clog2(N);
    localparam int QN     = N / 4;
    localparam int STAGES = 3;
    localparam int PW     = WIDTH + TW_WIDTH;
    localparam int SW     = PW + 1;

    logic [KW-1:0] k_q, k_d;
    logic [1:0]    quad;
    int unsigned   m_int;
    logic [KW-1:0] e_addr;

    // N is a power of two, so natural overflow gives the N-1 -> 0 wrap
    always_comb begin
        k_d    = enable_in ? k_q + KW'(1) : k_q;
        quad   = k_q[KW-1 -: 2];
        m_int  = 32'(k_q) % 32'(QN);
        e_addr = KW'(m_int * 32'(M_MAP[quad]));
    end

    logic signed [TW_WIDTH-1:0] wr1, wi1;

    twiddle_rom #(.N(N), .TW_WIDTH(TW_WIDTH)) u_rom (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr_i (e_addr),
        .wr_o   (wr1),
        .wi_o   (wi1)
    );

    logic [STAGES:1]         vld_pipe_q;
    logic signed [WIDTH-1:0] re1_q, im1_q, re2_q, im2_q;
    logic                    byp1_q, byp2_q;
    logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ri_q, p_ir_q;

    logic signed [SW-1:0]    sum_re, sum_im, rnd_re, rnd_im;
    logic signed [WIDTH-1:0] fit_re, fit_im;

    always_comb begin
        sum_re = SW'(p_rr_q) - SW'(p_ii_q);
        sum_im = SW'(p_ri_q) + SW'(p_ir_q);
        rnd_re = (sum_re + SW'(round_ofs(TW_WIDTH - 1))) >>> (TW_WIDTH - 1);
        rnd_im = (sum_im + SW'(round_ofs(TW_WIDTH - 1))) >>> (TW_WIDTH - 1);
`ifdef TWIDDLE_MUL_SAT_EN
        fit_re = WIDTH'(sat_to(32'(rnd_re), WIDTH));
        fit_im = WIDTH'(sat_to(32'(rnd_im), WIDTH));
`else
        fit_re = WIDTH'(rnd_re);
        fit_im = WIDTH'(rnd_im);
`endif
    end

    // Data path runs every cycle so gap outputs are deterministic; only valid bits gate meaning
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            vld_pipe_q <= '0;
            re1_q      <= '0;
            im1_q      <= '0;
            byp1_q     <= 1'b0;
            p_rr_q     <= '0;
            p_ii_q     <= '0;
            p_ri_q     <= '0;
            p_ir_q     <= '0;
            re2_q      <= '0;
            im2_q      <= '0;
            byp2_q     <= 1'b0;
            out_re     <= '0;
            out_im     <= '0;
        end else begin
            k_q        <= k_d;
            vld_pipe_q <= {vld_pipe_q[STAGES-1:1], enable_in};
            re1_q      <= in_re;
            im1_q      <= in_im;
            byp1_q     <= (e_addr == '0);
            p_rr_q     <= PW'(re1_q) * PW'(wr1);
            p_ii_q     <= PW'(im1_q) * PW'(wi1);
            p_ri_q     <= PW'(re1_q) * PW'(wi1);
            p_ir_q     <= PW'(im1_q) * PW'(wr1);
            re2_q      <= re1_q;
            im2_q      <= im1_q;
            byp2_q     <= byp1_q;
            // Unity twiddle is not representable in Q1.x, so e==0 passes the sample through
            out_re     <= byp2_q ? re2_q : fit_re;
            out_im     <= byp2_q ? im2_q : fit_im;
        end
    end

    assign enable_out = vld_pipe_q[STAGES];

endmodule

// File: tb/tb_twiddle_mul.sv
// Scoreboard bench for twiddle_mul: stimulus pushes expected samples, a monitor pops on enable_out.
module tb_twiddle_mul;
    localparam int    WIDTH    = 8;
    localparam int    TW_WIDTH = 8;
    localparam int    N        = 16;
    localparam real   PI       = 3.14159265358979323846;
    localparam int    QMAX     = (1 << (TW_WIDTH - 1)) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable_in = 1'b0;
    logic signed [WIDTH-1:0] in_re = '0;
    logic signed [WIDTH-1:0] in_im = '0;
    logic enable_out;
    logic signed [WIDTH-1:0] out_re, out_im;

    twiddle_mul #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable_in  (enable_in),
        .in_re      (in_re),
        .in_im      (in_im),
        .enable_out (enable_out),
        .out_re     (out_re),
        .out_im     (out_im)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    re;
        int    im;
        int    due;
        string tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   kb = 0;

    always @(posedge clk) cyc++;

    function automatic int qz(input real x);
        real v;
        int  r;
        v = x * real'(1 << (TW_WIDTH - 1));
        r = (v >= 0.0) ? $rtoi($floor(v + 0.5)) : -$rtoi($floor(-v + 0.5));
        return (r > QMAX) ? QMAX : r;
    endfunction

    function automatic int fit(input int v);
        int lo, hi, span, w;
        lo   = -(1 << (WIDTH - 1));
        hi   = (1 << (WIDTH - 1)) - 1;
        span = 1 << WIDTH;
`ifdef TWIDDLE_MUL_SAT_EN
        return (v > hi) ? hi : (v < lo) ? lo : v;
`else
        w = ((v % span) + span) % span;
        return (w > hi) ? w - span : w;
`endif
    endfunction

    // Reference: exponent from k, twiddle from real trig, product rounded half up
    task automatic model(input int k, input int xr, input int xi, output int yr, output int yi);
        int  mm[4];
        int  quarter, e, wr, wi, pr, pim;
        real ang, scale;
        mm      = '{0, 2, 1, 3};
        quarter = N / 4;
        e       = (k % quarter) * mm[k / quarter];
        if (e == 0) begin
            yr = xr;
            yi = xi;
        end else begin
            ang   = 2.0 * PI * e / N;
            scale = real'(1 << (TW_WIDTH - 1));
            wr    = qz($cos(ang));
            wi    = -qz($sin(ang));
            pr    = xr * wr - xi * wi;
            pim   = xr * wi + xi * wr;
            yr    = fit($rtoi($floor(real'(pr) / scale + 0.5)));
            yi    = fit($rtoi($floor(real'(pim) / scale + 0.5)));
        end
    endtask

    function automatic int rv();
        return int'($urandom_range((1 << WIDTH) - 1, 0)) - (1 << (WIDTH - 1));
    endfunction

    task automatic send(input int xr, input int xi, input bit use_exp,
                        input int er, input int ei, input string tag);
        int yr, yi;
        enable_in = 1'b1;
        in_re     = WIDTH'(xr);
        in_im     = WIDTH'(xi);
        if (use_exp) begin
            yr = er;
            yi = ei;
        end else begin
            model(kb, xr, xi, yr, yi);
        end
        sb.push_back('{yr, yi, cyc + 3, tag});
        kb = (kb + 1) % N;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        enable_in = 1'b0;
        repeat (n) begin
            in_re = WIDTH'(rv());
            in_im = WIDTH'(rv());
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            checks++;
            if (enable_out !== 1'b0 || out_re !== '0 || out_im !== '0) begin
                errors++;
                $display("FAIL reset_state: got en=%0b out=(%0d,%0d), want en=0 out=(0,0)",
                         enable_out, out_re, out_im);
            end
        end else if (enable_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got out=(%0d,%0d) at cyc %0d, want no output",
                         out_re, out_im, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (int'(out_re) != mon_e.re || int'(out_im) != mon_e.im || cyc != mon_e.due) begin
                    errors++;
                    $display("FAIL %s: got out=(%0d,%0d) at cyc %0d, want (%0d,%0d) at cyc %0d",
                             mon_e.tag, out_re, out_im, cyc, mon_e.re, mon_e.im, mon_e.due);
                end
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            checks++;
            errors++;
            mon_e = sb.pop_front();
            $display("FAIL missing_out %s: got enable_out=0 at cyc %0d, want (%0d,%0d)",
                     mon_e.tag, cyc, mon_e.re, mon_e.im);
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        enable_in = 1'b1;
        in_re = 8'sd100;
        in_im = -8'sd50;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) send(100, -50, 1'b1, 100, -50, "bypass_k0_4");
        send(64, 0, 1'b1, 46, -45, "k5_rotate");
        send(rv(), rv(), 1'b0, 0, 0, "k6_model");
        idle(3);
        send(rv(), rv(), 1'b0, 0, 0, "k7_after_gap");
        for (int i = 0; i < 13; i++) send(rv(), rv(), 1'b0, 0, 0, "wrap_k8_k4");
`ifdef TWIDDLE_MUL_SAT_EN
        send(-128, -128, 1'b1, -128, 0, "k5_saturate");
`else
        send(-128, -128, 1'b1, 74, 0, "k5_wrap");
`endif
        for (int i = 0; i < 3; i++) send(rv(), rv(), 1'b0, 0, 0, "k6_k8_model");

        // Asynchronous reset mid-cycle with samples in flight, counter at 9
        enable_in = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        sb.delete();
        kb = 0;
        #1;
        checks++;
        if (enable_out !== 1'b0) begin
            errors++;
            $display("FAIL async_drop: got enable_out=%0b, want 0", enable_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(77, -33, 1'b1, 77, -33, "post_reset_k0");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) == 0) idle(int'($urandom_range(3, 1)));
            send(rv(), rv(), 1'b0, 0, 0, "random");
        end
        idle(6);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d samples outstanding, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
